io_out_serializer: RTL and testbench

// Parallel-to-serial output stage that sits directly upstream of an IO block, feeding its OUT and TS inputs.
// It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per IOCLK.

---
 rtl/io_out_serializer.sv | 166 ++++++++++++++++
 tb/tb_io_out_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_out_serializer.sv
// Parallel-to-serial output stage feeding an IO block's OUT/TS pins.
// One shifter plus a one-word hold register; optional high-Z gap between drive/listen words.
module io_out_serializer #(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter int TURNAROUND = 1
) (
    input  logic             IOCLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_DRIVE,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             OUT,
    output logic             TS,
    output logic             BUSY,
    output logic             WORD_DONE
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               drive_q, drive_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_drive_q, hold_drive_d;
    logic               hold_full_q, hold_full_d;
    logic               out_q, out_d;
    logic               ts_q, ts_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               xfer;
    logic               has_next;
    logic [WIDTH-1:0]   next_word;
    logic               next_drive;
    logic               cur_bit;

    assign DIN_READY = ~hold_full_q;
    assign xfer      = DIN_VALID & ~hold_full_q & ~RST;

    assign OUT       = out_q;
    assign TS        = ts_q;
    assign BUSY      = busy_q;
    assign WORD_DONE = done_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        drive_d      = drive_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        hold_d       = hold_q;
        hold_drive_d = hold_drive_q;
        hold_full_d  = hold_full_q;
        has_next     = 1'b0;
        next_word    = DIN;
        next_drive   = DIN_DRIVE;

        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    shift_d   = DIN;
                    drive_d   = DIN_DRIVE;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q != LAST_BIT) begin
                    shift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (xfer) begin
                        hold_d       = DIN;
                        hold_drive_d = DIN_DRIVE;
                        hold_full_d  = 1'b1;
                    end
                end else begin
                    // Held word has priority; a same-edge transfer lands straight in the shifter.
                    if (hold_full_q) begin
                        has_next   = 1'b1;
                        next_word  = hold_q;
                        next_drive = hold_drive_q;
                    end else if (xfer) begin
                        has_next   = 1'b1;
                    end

                    if (!has_next) begin
                        state_d = ST_IDLE;
                    end else if (next_drive == drive_q || TURNAROUND == 0) begin
                        shift_d     = next_word;
                        drive_d     = next_drive;
                        bit_cnt_d   = '0;
                        hold_full_d = 1'b0;
                    end else begin
                        state_d      = ST_GAP;
                        gap_cnt_d    = 4'd0;
                        hold_d       = next_word;
                        hold_drive_d = next_drive;
                        hold_full_d  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    shift_d     = hold_q;
                    drive_d     = hold_drive_q;
                    bit_cnt_d   = '0;
                    hold_full_d = 1'b0;
                    state_d     = ST_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin outputs are registered from the next-state view so bit 0 appears right after the load edge.
        cur_bit = LSB_FIRST ? shift_d[0] : shift_d[WIDTH-1];
        ts_d    = (state_d == ST_SHIFT) & drive_d;
        out_d   = ts_d & cur_bit;
        done_d  = (state_d == ST_SHIFT) & (bit_cnt_d == LAST_BIT);
        busy_d  = (state_d != ST_IDLE) | hold_full_d;
    end

    always_ff @(posedge IOCLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            drive_q      <= 1'b0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= 4'd0;
            hold_q       <= '0;
            hold_drive_q <= 1'b0;
            hold_full_q  <= 1'b0;
            out_q        <= 1'b0;
            ts_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            drive_q      <= drive_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            hold_q       <= hold_d;
            hold_drive_q <= hold_drive_d;
            hold_full_q  <= hold_full_d;
            out_q        <= out_d;
            ts_q         <= ts_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_io_out_serializer.sv
// Bench for io_out_serializer: LSB-first and MSB-first instances share stimulus;
// a queue-based schedule model predicts every output cycle.
module tb_io_out_serializer;

    localparam int TA = 1;

    logic       IOCLK;
    logic       rst;
    logic [7:0] din;
    logic       din_drive;
    logic       din_valid;
    logic       rdy_l, out_l, ts_l, busy_l, done_l;
    logic       rdy_m, out_m, ts_m, busy_m, done_m;

    int checks = 0;
    int errors = 0;

    io_out_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .TURNAROUND(TA)) u_lsb (
        .IOCLK(IOCLK), .RST(rst), .DIN(din), .DIN_DRIVE(din_drive), .DIN_VALID(din_valid),
        .DIN_READY(rdy_l), .OUT(out_l), .TS(ts_l), .BUSY(busy_l), .WORD_DONE(done_l)
    );

    io_out_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .TURNAROUND(TA)) u_msb (
        .IOCLK(IOCLK), .RST(rst), .DIN(din), .DIN_DRIVE(din_drive), .DIN_VALID(din_valid),
        .DIN_READY(rdy_m), .OUT(out_m), .TS(ts_m), .BUSY(busy_m), .WORD_DONE(done_m)
    );

    initial begin
        IOCLK = 1'b0;
        forever #5 IOCLK = ~IOCLK;
    end

    // Model: a schedule of future pin cycles. kind 0 = idle, 1 = gap, 2 = word bit.
    typedef struct {
        logic [7:0] w;
        int         idx;
        bit         drv;
        int         kind;
    } rec_t;

    rec_t sched[$];
    rec_t cur;
    bit   last_drv;

    function automatic rec_t idle_rec();
        rec_t r;
        r.w = 8'h00; r.idx = 0; r.drv = 1'b0; r.kind = 0;
        return r;
    endfunction

    // A word waits in hold while its first bit has not been scheduled out yet.
    function automatic bit m_ready();
        foreach (sched[i])
            if (sched[i].kind == 2 && sched[i].idx == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit r, input bit acc, input logic [7:0] d, input bit dr);
        rec_t x;
        if (r) begin
            sched.delete();
            cur = idle_rec();
        end else begin
            if (acc) begin
                if ((sched.size() > 0 || cur.kind == 2) && last_drv != dr)
                    for (int g = 0; g < TA; g++) begin
                        x = idle_rec(); x.kind = 1;
                        sched.push_back(x);
                    end
                for (int b = 0; b < 8; b++) begin
                    x.w = d; x.idx = b; x.drv = dr; x.kind = 2;
                    sched.push_back(x);
                end
                last_drv = dr;
            end
            cur = (sched.size() > 0) ? sched.pop_front() : idle_rec();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit dr);
        bit exp_rdy, acc, e_ts, e_done;
        logic [7:0] w;
        rst = r; din_valid = v; din = d; din_drive = dr;
        exp_rdy = m_ready();
        if (!r) begin
            chk("ready_lsb", rdy_l, exp_rdy);
            chk("ready_msb", rdy_m, exp_rdy);
        end
        acc = !r && v && exp_rdy;
        @(posedge IOCLK);
        model_edge(r, acc, d, dr);
        #1;
        w      = cur.w;
        e_ts   = (cur.kind == 2) && cur.drv;
        e_done = (cur.kind == 2) && (cur.idx == 7);
        chk("out_lsb", out_l, e_ts ? w[cur.idx] : 1'b0);
        chk("out_msb", out_m, e_ts ? w[7 - cur.idx] : 1'b0);
        chk("ts", ts_l, e_ts);
        chk("ts_msb", ts_m, e_ts);
        chk("done", done_l, e_done);
        chk("done_msb", done_m, e_done);
        chk("busy", busy_l, cur.kind != 0);
        chk("busy_msb", busy_m, cur.kind != 0);
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         dr;
        bit         out_l;
        bit         out_m;
        bit         ts;
        bit         done;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int  ts_run, ts_max, done_n, d1, d2, busy_n, ts_n, listen_out;
        bit  sent, saw_low, v;

        cur = idle_rec();
        last_drv = 1'b0;
        rst = 1'b1; din = 8'h00; din_drive = 1'b0; din_valid = 1'b0;

        tbl[0] = '{1'b1, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset for two cycles, then idle outputs and ready.
        cycle(1, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", rdy_l, 1'b1);
        chk("rst_out", out_l, 1'b0);
        chk("rst_ts", ts_l, 1'b0);
        chk("rst_busy", busy_l, 1'b0);
        chk("rst_done", done_l, 1'b0);
        cycle(0, 0, 8'h00, 0);

        // 0x2C drive word, both bit orders.
        for (int i = 0; i < 10; i++) begin
            cycle(0, tbl[i].v, tbl[i].d, tbl[i].dr);
            chk("tbl_out_lsb", out_l, tbl[i].out_l);
            chk("tbl_out_msb", out_m, tbl[i].out_m);
            chk("tbl_ts", ts_l, tbl[i].ts);
            chk("tbl_done", done_l, tbl[i].done);
        end

        // Back-to-back drive words with valid held: contiguous 16-cycle burst.
        cycle(0, 1, 8'h0F, 1);
        ts_run = ts_l ? 1 : 0; ts_max = ts_run; done_n = 0; d1 = -1; d2 = -1;
        sent = 1'b0; saw_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            v = !sent;
            if (v && m_ready()) sent = 1'b1;
            cycle(0, v, 8'hF0, 1);
            if (!rdy_l) saw_low = 1'b1;
            ts_run = ts_l ? ts_run + 1 : 0;
            if (ts_run > ts_max) ts_max = ts_run;
            if (done_l) begin
                done_n++;
                if (d1 < 0) d1 = i; else d2 = i;
            end
        end
        chk("b2b_ts_run", ts_max, 16);
        chk("b2b_done_cnt", done_n, 2);
        chk("b2b_done_gap", d2 - d1, 8);
        chk("b2b_ready_low", saw_low, 1'b1);

        // Drive word then listen word: one gap cycle, 17 busy cycles.
        cycle(0, 1, 8'hA5, 1);
        busy_n = busy_l ? 1 : 0; ts_n = ts_l ? 1 : 0; listen_out = 0; done_n = 0;
        sent = 1'b0;
        for (int i = 0; i < 24; i++) begin
            v = !sent;
            if (v && m_ready()) sent = 1'b1;
            cycle(0, v, 8'h3C, 0);
            if (busy_l) busy_n++;
            if (ts_l) ts_n++;
            if (busy_l && !ts_l && out_l) listen_out++;
            if (done_l) done_n++;
        end
        chk("turn_busy_cycles", busy_n, 17);
        chk("turn_ts_cycles", ts_n, 8);
        chk("turn_listen_out", listen_out, 0);
        chk("turn_done_cnt", done_n, 2);

        // Reset at bit 3 with the hold register full.
        cycle(0, 1, 8'hC3, 1);
        cycle(0, 1, 8'h5A, 1);
        cycle(0, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 0);
        chk("abort_hold_full", rdy_l, 1'b0);
        cycle(1, 0, 8'h00, 0);
        chk("abort_ts", ts_l, 1'b0);
        chk("abort_out", out_l, 1'b0);
        chk("abort_busy", busy_l, 1'b0);
        chk("abort_done", done_l, 1'b0);
        cycle(0, 0, 8'h00, 0);
        chk("abort_ready", rdy_l, 1'b1);
        chk("abort_no_done", done_l, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                  8'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 30; i++) cycle(0, 0, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
